mem_port_arbiter: RTL and testbench

//   Shares one synchronous single-port RAM between the instruction-fetch requester and the
//   MEM-stage load/store requester of the 5-stage core (unified memory). Grants at most one

---
 rtl/mem_port_arbiter_pkg.sv | 27 ++
 rtl/mem_port_arbiter_if.sv | 53 +++++
 rtl/mem_arb_starve_ctr.sv | 41 ++++
 rtl/mem_port_arbiter.sv | 114 +++++++++++
 tb/tb_mem_port_arbiter.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified-memory port arbiter: priority state, read-owner tag
// and the word-width code used for instruction fetches.
package mem_port_arbiter_pkg;

    typedef enum logic [0:0] {
        PRI_D  = 1'b0,
        PRI_IF = 1'b1
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } arb_owner_e;

    localparam logic [2:0] WID_WORD = 3'b010;

    localparam int ADDR_W_DEF       = 16;
    localparam int DATA_W_DEF       = 64;
    localparam int STARVE_LIMIT_DEF = 4;

    // Counter must be able to hold STARVE_LIMIT itself, where it saturates.
    function automatic int starve_cnt_w(input int limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, load/store and RAM-side signals around the memory port arbiter.
// Signal suffixes are relative to the arbiter (slave modport).
interface mem_port_arbiter_if
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              flush_i;

    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_gnt_o;
    logic              if_rvalid_o;
    logic [DATA_W-1:0] if_rdata_o;

    logic              d_req_i;
    logic              d_we_i;
    logic [ADDR_W-1:0] d_addr_i;
    logic [DATA_W-1:0] d_wdata_i;
    logic [2:0]        d_wid_i;
    logic              d_gnt_o;
    logic              d_rvalid_o;
    logic [DATA_W-1:0] d_rdata_o;

    logic              ram_en_o;
    logic              ram_we_o;
    logic [ADDR_W-1:0] ram_addr_o;
    logic [DATA_W-1:0] ram_wdata_o;
    logic [2:0]        ram_wid_o;
    logic [DATA_W-1:0] ram_rdata_i;

    modport slave (
        input  flush_i,
        input  if_req_i, if_addr_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o,
        input  d_req_i, d_we_i, d_addr_i, d_wdata_i, d_wid_i,
        output d_gnt_o, d_rvalid_o, d_rdata_o,
        output ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o, ram_wid_o,
        input  ram_rdata_i
    );

    modport master (
        output flush_i,
        output if_req_i, if_addr_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o,
        output d_req_i, d_we_i, d_addr_i, d_wdata_i, d_wid_i,
        input  d_gnt_o, d_rvalid_o, d_rdata_o,
        input  ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o, ram_wid_o,
        output ram_rdata_i
    );

endinterface

// File: rtl/mem_arb_starve_ctr.sv
// Counts consecutive cycles the fetch requester is denied; flags the cycle on which
// one more denial reaches the starvation limit.
module mem_arb_starve_ctr
    import mem_port_arbiter_pkg::*;
#(
    parameter  int STARVE_LIMIT = STARVE_LIMIT_DEF,
    localparam int CNT_W        = starve_cnt_w(STARVE_LIMIT)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic req_i,
    input  logic gnt_i,
    output logic at_limit_o
);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARVE_LIMIT - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (!req_i || gnt_i) begin
            cnt_next = '0;
        end else if (cnt_reg != CNT_MAX) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign at_limit_o = (cnt_reg == CNT_LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter between instruction fetch and MEM-stage load/store.
// One combinational grant per cycle, 1-cycle read return routed to its owner.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                clk_i,
    input  logic                rst_i,
    mem_port_arbiter_if.slave   bus
);

    arb_state_e        state_reg;
    arb_state_e        state_next;
    arb_owner_e        rd_owner_reg;
    arb_owner_e        rd_owner_next;

    logic              if_gnt;
    logic              d_gnt;
    logic              starve_at_limit;
    logic [ADDR_W-1:0] ram_addr_mux;
    logic [DATA_W-1:0] ram_wdata_mux;
    logic [2:0]        ram_wid_mux;

    mem_arb_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .req_i      (bus.if_req_i),
        .gnt_i      (if_gnt),
        .at_limit_o (starve_at_limit)
    );

    // A flush removes fetch from contention, so a waiting load/store wins in either state.
    always_comb begin
        if_gnt     = 1'b0;
        d_gnt      = 1'b0;
        state_next = state_reg;

        if (!rst_i) begin
            if_gnt = bus.if_req_i && !bus.flush_i
                     && ((state_reg == PRI_IF) || !bus.d_req_i);
            d_gnt  = bus.d_req_i && !if_gnt;
        end

        case (state_reg)
            PRI_D: begin
                if (starve_at_limit && bus.if_req_i && !if_gnt) begin
                    state_next = PRI_IF;
                end
            end
            PRI_IF: begin
                if (if_gnt || !bus.if_req_i) begin
                    state_next = PRI_D;
                end
            end
            default: state_next = PRI_D;
        endcase
    end

    always_comb begin
        rd_owner_next = OWN_NONE;
        if (if_gnt) begin
            rd_owner_next = OWN_IF;
        end else if (d_gnt && !bus.d_we_i) begin
            rd_owner_next = OWN_D;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg    <= PRI_D;
            rd_owner_reg <= OWN_NONE;
        end else begin
            state_reg    <= state_next;
            rd_owner_reg <= rd_owner_next;
        end
    end

    // Idle cycles drive zeros so the RAM bus is quiet when nobody owns it.
    always_comb begin
        ram_addr_mux  = '0;
        ram_wdata_mux = '0;
        ram_wid_mux   = 3'b000;
        if (d_gnt) begin
            ram_addr_mux = bus.d_addr_i;
            ram_wid_mux  = bus.d_wid_i;
            if (bus.d_we_i) begin
                ram_wdata_mux = bus.d_wdata_i;
            end
        end else if (if_gnt) begin
            ram_addr_mux = bus.if_addr_i;
            ram_wid_mux  = WID_WORD;
        end
    end

    assign bus.if_gnt_o    = if_gnt;
    assign bus.d_gnt_o     = d_gnt;

    assign bus.ram_en_o    = if_gnt || d_gnt;
    assign bus.ram_we_o    = d_gnt && bus.d_we_i;
    assign bus.ram_addr_o  = ram_addr_mux;
    assign bus.ram_wdata_o = ram_wdata_mux;
    assign bus.ram_wid_o   = ram_wid_mux;

    assign bus.if_rvalid_o = !rst_i && (rd_owner_reg == OWN_IF) && !bus.flush_i;
    assign bus.d_rvalid_o  = !rst_i && (rd_owner_reg == OWN_D);
    assign bus.if_rdata_o  = bus.ram_rdata_i;
    assign bus.d_rdata_o   = bus.ram_rdata_i;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, interleave sequence and
// randomized traffic checked against a consecutive-denial reference model.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int ADDR_W       = 16;
    localparam int DATA_W       = 64;
    localparam int STARVE_LIMIT = 4;
    localparam logic [63:0] Z   = 64'h0;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    logic preload = 1'b1;

    always #5 clk_i = ~clk_i;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    function automatic logic [63:0] pat(input int i);
        if (i == 16) return 64'h13;
        return {16'hA5A5, 16'(i), 32'h1000_0000 + 32'(i)};
    endfunction

    // RAM environment: synchronous single port, registered read.
    logic [63:0] ram_mem [1024];
    always @(posedge clk_i) begin
        if (preload) begin
            for (int i = 0; i < 1024; i++) ram_mem[i] <= pat(i);
        end else if (bus.ram_en_o) begin
            if (bus.ram_we_o) ram_mem[bus.ram_addr_o[9:0]] <= bus.ram_wdata_o;
            else              bus.ram_rdata_i <= ram_mem[bus.ram_addr_o[9:0]];
        end
    end

    // Reference model: IF has priority once it has been denied STARVE_LIMIT
    // consecutive requesting cycles; reads return one cycle later to their owner.
    logic [63:0] shadow [1024];
    int          wait_cnt  = 0;
    int          pend      = 0;   // 0 none, 1 fetch, 2 load
    logic [63:0] pend_data = 64'h0;
    int          want_ifg  = -1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        rst, flush, ifr;
        logic [15:0] ifa;
        logic        dr, dwe;
        logic [15:0] da;
        logic [63:0] dwd;
        logic [2:0]  dwid;
        logic        e_ifg, e_dg, e_ifrv, e_drv, e_we;
        logic [63:0] e_rd;
        logic [2:0]  e_wid;
    } vec_t;

    function automatic vec_t mk(int rst, int flush, int ifr, int ifa, int dr, int dwe,
                                int da, logic [63:0] dwd, int dwid, int e_ifg, int e_dg,
                                int e_ifrv, int e_drv, int e_we, logic [63:0] e_rd,
                                int e_wid);
        vec_t v;
        v.rst = 1'(rst);     v.flush = 1'(flush); v.ifr = 1'(ifr);   v.ifa = 16'(ifa);
        v.dr = 1'(dr);       v.dwe = 1'(dwe);     v.da = 16'(da);    v.dwd = dwd;
        v.dwid = 3'(dwid);   v.e_ifg = 1'(e_ifg); v.e_dg = 1'(e_dg); v.e_ifrv = 1'(e_ifrv);
        v.e_drv = 1'(e_drv); v.e_we = 1'(e_we);   v.e_rd = e_rd;     v.e_wid = 3'(e_wid);
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic fl, input logic ifr, input logic [15:0] ifa,
                         input logic dr, input logic dwe, input logic [15:0] da,
                         input logic [63:0] dwd, input logic [2:0] dwid);
        rst_i = r;            bus.flush_i = fl;
        bus.if_req_i = ifr;   bus.if_addr_i = ifa;
        bus.d_req_i = dr;     bus.d_we_i = dwe;   bus.d_addr_i = da;
        bus.d_wdata_i = dwd;  bus.d_wid_i = dwid;
    endtask

    task automatic run_cycle(input string tag, input bit use_vec, input vec_t v);
        logic r, fl, ifr, dr, dwe;
        logic [15:0] ifa, da;
        logic [63:0] dwd;
        logic [2:0]  dwid;
        logic eg_if, eg_d, erv_if, erv_d, ifp;
        @(negedge clk_i);
        r = rst_i; fl = bus.flush_i; ifr = bus.if_req_i; ifa = bus.if_addr_i;
        dr = bus.d_req_i; dwe = bus.d_we_i; da = bus.d_addr_i; dwd = bus.d_wdata_i;
        dwid = bus.d_wid_i;
        ifp = (wait_cnt >= STARVE_LIMIT);
        if (r) begin
            eg_if = 1'b0; eg_d = 1'b0; erv_if = 1'b0; erv_d = 1'b0;
        end else begin
            eg_if  = ifr && !fl && (!dr || ifp);
            eg_d   = dr && !eg_if;
            erv_if = (pend == 1) && !fl;
            erv_d  = (pend == 2);
        end

        if (use_vec) begin
            chk({tag, " if_gnt"},    64'(bus.if_gnt_o),    64'(v.e_ifg));
            chk({tag, " d_gnt"},     64'(bus.d_gnt_o),     64'(v.e_dg));
            chk({tag, " if_rvalid"}, 64'(bus.if_rvalid_o), 64'(v.e_ifrv));
            chk({tag, " d_rvalid"},  64'(bus.d_rvalid_o),  64'(v.e_drv));
            chk({tag, " ram_we"},    64'(bus.ram_we_o),    64'(v.e_we));
            if (v.e_ifg || v.e_dg) chk({tag, " ram_wid"}, 64'(bus.ram_wid_o), 64'(v.e_wid));
            if (v.e_ifrv) chk({tag, " if_rdata"}, bus.if_rdata_o, v.e_rd);
            if (v.e_drv)  chk({tag, " d_rdata"},  bus.d_rdata_o,  v.e_rd);
        end
        if (want_ifg >= 0) chk({tag, " ilv_if_gnt"}, 64'(bus.if_gnt_o), 64'(want_ifg));

        chk({tag, " m_if_gnt"},    64'(bus.if_gnt_o),    64'(eg_if));
        chk({tag, " m_d_gnt"},     64'(bus.d_gnt_o),     64'(eg_d));
        chk({tag, " m_ram_en"},    64'(bus.ram_en_o),    64'(eg_if || eg_d));
        chk({tag, " m_ram_we"},    64'(bus.ram_we_o),    64'(eg_d && dwe));
        if (eg_d || eg_if) begin
            chk({tag, " m_ram_addr"}, 64'(bus.ram_addr_o), 64'(eg_d ? da : ifa));
            chk({tag, " m_ram_wid"},  64'(bus.ram_wid_o),  64'(eg_d ? dwid : WID_WORD));
        end
        if (eg_d && dwe) chk({tag, " m_ram_wdata"}, bus.ram_wdata_o, dwd);
        chk({tag, " m_if_rvalid"}, 64'(bus.if_rvalid_o), 64'(erv_if));
        chk({tag, " m_d_rvalid"},  64'(bus.d_rvalid_o),  64'(erv_d));
        if (erv_if) chk({tag, " m_if_rdata"}, bus.if_rdata_o, pend_data);
        if (erv_d)  chk({tag, " m_d_rdata"},  bus.d_rdata_o,  pend_data);
        chk({tag, " both_rvalid"}, 64'(bus.if_rvalid_o && bus.d_rvalid_o), Z);

        $display("%s rst=%b fl=%b ifr=%b dr=%b we=%b | ifg=%b dg=%b ifrv=%b drv=%b addr=%h",
                 tag, r, fl, ifr, dr, dwe, bus.if_gnt_o, bus.d_gnt_o,
                 bus.if_rvalid_o, bus.d_rvalid_o, bus.ram_addr_o);

        @(posedge clk_i);
        if (r) begin
            wait_cnt = 0;
            pend     = 0;
        end else begin
            wait_cnt = (ifr && !eg_if) ? wait_cnt + 1 : 0;
            if (eg_if) begin
                pend = 1; pend_data = shadow[ifa[9:0]];
            end else if (eg_d && !dwe) begin
                pend = 2; pend_data = shadow[da[9:0]];
            end else begin
                pend = 0;
            end
            if (eg_d && dwe) shadow[da[9:0]] = dwd;
        end
        #1;
    endtask

    vec_t tbl[$];
    vec_t nv;

    initial begin
        for (int i = 0; i < 1024; i++) shadow[i] = pat(i);
        nv = mk(0, 0, 0, 0, 0, 0, 0, Z, 0, 0, 0, 0, 0, 0, Z, 0);
        drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, Z, 3'b0);
        repeat (2) @(posedge clk_i);
        #1 preload = 1'b0;

        // rst flush ifr ifa dr we da wdata wid | ifg dg ifrv drv we rdata wid
        tbl.push_back(mk(1,0,0,0,     0,0,0,     Z,0, 0,0,0,0,0, Z,0));
        tbl.push_back(mk(0,0,1,'h10,  0,0,0,     Z,0, 1,0,0,0,0, Z,2));
        tbl.push_back(mk(0,0,0,0,     0,0,0,     Z,0, 0,0,1,0,0, 64'h13,0));
        tbl.push_back(mk(0,0,0,0,     1,1,'h100, 64'hDEADBEEF_CAFEF00D,3, 0,1,0,0,1, Z,3));
        tbl.push_back(mk(0,0,0,0,     1,0,'h100, Z,3, 0,1,0,0,0, Z,3));
        tbl.push_back(mk(0,0,0,0,     0,0,0,     Z,0, 0,0,0,1,0, 64'hDEADBEEF_CAFEF00D,0));
        tbl.push_back(mk(0,0,1,'h30,  1,0,'h20,  Z,3, 0,1,0,0,0, Z,3));
        tbl.push_back(mk(0,0,1,'h30,  1,0,'h20,  Z,3, 0,1,0,1,0, pat('h20),3));
        tbl.push_back(mk(0,0,1,'h30,  1,0,'h20,  Z,3, 0,1,0,1,0, pat('h20),3));
        tbl.push_back(mk(0,0,1,'h30,  1,0,'h20,  Z,3, 0,1,0,1,0, pat('h20),3));
        tbl.push_back(mk(0,0,1,'h30,  1,0,'h20,  Z,3, 1,0,0,1,0, pat('h20),2));
        tbl.push_back(mk(0,0,1,'h30,  1,0,'h20,  Z,3, 0,1,1,0,0, pat('h30),3));
        tbl.push_back(mk(0,0,0,0,     0,0,0,     Z,0, 0,0,0,1,0, pat('h20),0));
        tbl.push_back(mk(0,0,1,'h40,  0,0,0,     Z,0, 1,0,0,0,0, Z,2));
        tbl.push_back(mk(0,1,1,'h44,  1,0,'h50,  Z,3, 0,1,0,0,0, Z,3));
        tbl.push_back(mk(0,0,0,0,     0,0,0,     Z,0, 0,0,0,1,0, pat('h50),0));
        tbl.push_back(mk(0,0,0,0,     1,0,'h60,  Z,3, 0,1,0,0,0, Z,3));
        tbl.push_back(mk(1,0,0,0,     1,0,'h60,  Z,3, 0,0,0,0,0, Z,0));
        tbl.push_back(mk(0,0,0,0,     0,0,0,     Z,0, 0,0,0,0,0, Z,0));
        tbl.push_back(mk(0,0,1,'h78,  1,0,'h70,  Z,3, 0,1,0,0,0, Z,3));
        tbl.push_back(mk(0,0,0,0,     0,0,0,     Z,0, 0,0,0,1,0, pat('h70),0));

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].flush, tbl[i].ifr, tbl[i].ifa, tbl[i].dr,
                  tbl[i].dwe, tbl[i].da, tbl[i].dwd, tbl[i].dwid);
            run_cycle($sformatf("vec%0d", i), 1'b1, tbl[i]);
        end

        // Interleave: fetch always requesting, load on every other cycle.
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b0, 1'b1, 16'(8 * i), (i % 2) == 0, 1'b0, 16'(8 * i + 256),
                  Z, 3'b011);
            want_ifg = ((i % 2) == 1) ? 1 : -1;
            run_cycle($sformatf("ilv%0d", i), 1'b0, nv);
        end
        want_ifg = -1;

        // Randomized traffic with alternating light/heavy data-side load.
        for (int i = 0; i < 600; i++) begin
            int dprob;
            dprob = ((i / 50) % 2 == 0) ? 35 : 92;
            drive($urandom_range(0, 59) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 9) < 7, 16'($urandom_range(0, 127) * 8),
                  $urandom_range(0, 99) < dprob, $urandom_range(0, 9) < 4,
                  16'($urandom_range(0, 127) * 8), {$urandom, $urandom},
                  3'($urandom_range(0, 7)));
            run_cycle($sformatf("rnd%0d", i), 1'b0, nv);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
